// File: rtl/sb_arbiter.sv
// Arbitrates the single sb memory port between fetch and load/store; request to valid is 2 cycles minimum.
// Backpressure: m_req is held until m_ready (aborted after TIMEOUT cycles); hold_o stalls the data side until d_valid.
module sb_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int TIMEOUT    = 16,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_valid,
  output logic [DATA_W-1:0] i_inst,
  input  logic              d_re,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  input  logic [1:0]        d_size,
  input  logic              d_un_sign,
  output logic              d_valid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              hold_o,
  output logic              bus_err,
  output logic              m_req,
  output logic              m_we,
  output logic [ADDR_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_wdata,
  output logic [3:0]        m_be,
  input  logic              m_ready,
  input  logic [DATA_W-1:0] m_rdata
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] IFETCH = 2'd1;
  localparam logic [1:0] DACC   = 2'd2;

  localparam int WAIT_W   = $clog2(TIMEOUT + 1);
  localparam int STARVE_W = $clog2(STARVE_MAX + 1);
  localparam logic [WAIT_W-1:0]   WAIT_LAST  = WAIT_W'(TIMEOUT - 1);
  localparam logic [STARVE_W-1:0] STARVE_LIM = STARVE_W'(STARVE_MAX);

  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [3:0]        be;
    logic [1:0]        size;
    logic              un_sign;
  } acc_t;

  logic [1:0]          state;
  acc_t                acc;
  logic [WAIT_W-1:0]   wait_cnt;
  logic [STARVE_W-1:0] starve_cnt;
  logic                d_any;
  logic                data_win;

  function automatic logic [3:0] lane_be(input logic [1:0] size, input logic [1:0] a);
    case (size)
      2'b00:   lane_be = 4'b0001 << a;
      2'b01:   lane_be = a[1] ? 4'b1100 : 4'b0011;
      default: lane_be = 4'b1111;
    endcase
  endfunction

  function automatic logic [DATA_W-1:0] store_lanes(input logic [DATA_W-1:0] wd,
                                                    input logic [1:0] size);
    case (size)
      2'b00:   store_lanes = {4{wd[7:0]}};
      2'b01:   store_lanes = {2{wd[15:0]}};
      default: store_lanes = wd;
    endcase
  endfunction

  // Lane select by byte offset, then extend; size 11 behaves as a word.
  function automatic logic [DATA_W-1:0] load_ext(input logic [DATA_W-1:0] rd,
                                                 input logic [1:0] size,
                                                 input logic [1:0] a,
                                                 input logic un_sign);
    logic [7:0]  b;
    logic [15:0] h;
    b = rd[{a, 3'b000} +: 8];
    h = a[1] ? rd[31:16] : rd[15:0];
    case (size)
      2'b00:   load_ext = un_sign ? {24'b0, b} : {{24{b[7]}}, b};
      2'b01:   load_ext = un_sign ? {16'b0, h} : {{16{h[15]}}, h};
      default: load_ext = rd;
    endcase
  endfunction

  assign d_any    = d_re | d_we;
  assign data_win = d_any && (starve_cnt < STARVE_LIM);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= IDLE;
      acc        <= '0;
      wait_cnt   <= '0;
      starve_cnt <= '0;
      i_valid    <= 1'b0;
      i_inst     <= '0;
      d_valid    <= 1'b0;
      d_rdata    <= '0;
      bus_err    <= 1'b0;
    end else begin
      i_valid <= 1'b0;
      d_valid <= 1'b0;
      bus_err <= 1'b0;
      case (state)
        IDLE: begin
          wait_cnt <= '0;
          if (data_win) begin
            state       <= DACC;
            acc.we      <= ~d_re;
            acc.addr    <= d_addr;
            acc.wdata   <= store_lanes(d_wdata, d_size);
            acc.be      <= lane_be(d_size, d_addr[1:0]);
            acc.size    <= d_size;
            acc.un_sign <= d_un_sign;
            if (!i_req)
              starve_cnt <= '0;
            else if (starve_cnt != STARVE_LIM)
              starve_cnt <= starve_cnt + 1'b1;
          end else if (i_req) begin
            state       <= IFETCH;
            acc.we      <= 1'b0;
            acc.addr    <= i_addr;
            acc.wdata   <= '0;
            acc.be      <= 4'b1111;
            acc.size    <= 2'b10;
            acc.un_sign <= 1'b0;
            starve_cnt  <= '0;
          end
        end
        IFETCH, DACC: begin
          if (m_ready) begin
            state <= IDLE;
            if (state == IFETCH) begin
              i_valid <= 1'b1;
              i_inst  <= m_rdata;
            end else begin
              d_valid <= 1'b1;
              d_rdata <= acc.we ? '0 : load_ext(m_rdata, acc.size, acc.addr[1:0], acc.un_sign);
            end
          end else if (wait_cnt == WAIT_LAST) begin
            // Abort: the requester still gets its valid pulse, with zero data.
            state   <= IDLE;
            bus_err <= 1'b1;
            if (state == IFETCH) begin
              i_valid <= 1'b1;
              i_inst  <= '0;
            end else begin
              d_valid <= 1'b1;
              d_rdata <= '0;
            end
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign m_req   = (state == IFETCH) || (state == DACC);
  assign m_we    = m_req & acc.we;
  assign m_addr  = {acc.addr[ADDR_W-1:2], 2'b00};
  assign m_wdata = acc.wdata;
  assign m_be    = acc.be;
  assign hold_o  = d_any & ~d_valid;

endmodule

// File: tb/tb_sb_arbiter.sv
// Table-driven check of sb_arbiter lanes, handshake timing, arbitration fairness, timeout and reset abort.
module tb_sb_arbiter;

  localparam logic [31:0] K = 32'hA5A5_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        i_req = 1'b0;
  logic [31:0] i_addr = '0;
  logic        i_valid;
  logic [31:0] i_inst;
  logic        d_re = 1'b0, d_we = 1'b0;
  logic [31:0] d_addr = '0, d_wdata = '0;
  logic [1:0]  d_size = '0;
  logic        d_un_sign = 1'b0;
  logic        d_valid;
  logic [31:0] d_rdata;
  logic        hold_o, bus_err, m_req, m_we;
  logic [31:0] m_addr, m_wdata;
  logic [3:0]  m_be;
  logic        m_ready;
  logic [31:0] m_rdata;

  logic        auto_ready = 1'b0;
  logic        drv_ready = 1'b0;
  logic [31:0] drv_rdata = '0;

  assign m_ready = auto_ready ? m_req : drv_ready;
  assign m_rdata = auto_ready ? (m_addr ^ K) : drv_rdata;

  sb_arbiter dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_valid(i_valid), .i_inst(i_inst),
    .d_re(d_re), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_size(d_size), .d_un_sign(d_un_sign), .d_valid(d_valid), .d_rdata(d_rdata),
    .hold_o(hold_o), .bus_err(bus_err),
    .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata), .m_be(m_be),
    .m_ready(m_ready), .m_rdata(m_rdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          fetch;
    bit          re;
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [1:0]  size;
    bit          un_sign;
    logic [31:0] mem;
    int          lat;
    logic [3:0]  e_be;
    logic [31:0] e_wdata;
    logic [31:0] e_rdata;
  } vec_t;

  typedef struct {
    bit          is_data;
    logic [31:0] data;
    bit          chk_data;
    bit          err;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  vec_t vecs[13];
  int   n_tests = 0;
  int   n_fail  = 0;
  bit   mon_en  = 1'b0;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  task automatic push_exp(input bit is_data, input logic [31:0] data, input bit chk_data, input bit err);
    exp_t e;
    e.is_data  = is_data;
    e.data     = data;
    e.chk_data = chk_data;
    e.err      = err;
    sb_q.push_back(e);
  endtask

  task automatic drain();
    for (int k = 0; k < 8 && sb_q.size() != 0; k++) @(negedge clk);
    chk("scoreboard_drain", sb_q.size(), 0);
    sb_q.delete();
  endtask

  task automatic idle_inputs();
    i_req = 1'b0; d_re = 1'b0; d_we = 1'b0;
  endtask

  // Every valid pulse retires the oldest expectation.
  always @(negedge clk) begin
    if (mon_en && (i_valid === 1'b1 || d_valid === 1'b1)) begin
      if (sb_q.size() == 0) begin
        chk("unexpected_valid", {30'b0, i_valid, d_valid}, 32'h0);
      end else begin
        mon_e = sb_q.pop_front();
        chk("valid_kind", {30'b0, i_valid, d_valid}, mon_e.is_data ? 32'h1 : 32'h2);
        if (mon_e.chk_data)
          chk(mon_e.is_data ? "d_rdata" : "i_inst", mon_e.is_data ? d_rdata : i_inst, mon_e.data);
        chk("bus_err_on_valid", bus_err, mon_e.err);
      end
    end
  end

  task automatic run_one(input vec_t v, input int idx);
    bit is_data;
    is_data   = !v.fetch;
    i_req     = v.fetch;
    i_addr    = v.addr;
    d_re      = v.re;
    d_we      = v.we;
    d_addr    = v.addr;
    d_wdata   = v.wdata;
    d_size    = v.size;
    d_un_sign = v.un_sign;
    drv_ready = 1'b0;
    push_exp(is_data, v.e_rdata, v.fetch || v.re, 1'b0);
    #1 chk($sformatf("v%0d_hold_req", idx), hold_o, is_data);
    @(negedge clk);
    chk($sformatf("v%0d_m_req", idx), m_req, 1);
    chk($sformatf("v%0d_m_addr", idx), m_addr, v.addr & 32'hFFFF_FFFC);
    chk($sformatf("v%0d_m_be", idx), m_be, v.e_be);
    chk($sformatf("v%0d_m_we", idx), m_we, is_data && v.we && !v.re);
    if (is_data && v.we && !v.re) chk($sformatf("v%0d_m_wdata", idx), m_wdata, v.e_wdata);
    for (int k = 0; k < v.lat; k++) begin
      @(negedge clk);
      chk($sformatf("v%0d_m_req_held", idx), m_req, 1);
      chk($sformatf("v%0d_m_addr_held", idx), m_addr, v.addr & 32'hFFFF_FFFC);
      if (is_data) chk($sformatf("v%0d_hold_wait", idx), hold_o, 1);
    end
    drv_ready = 1'b1;
    drv_rdata = v.mem;
    @(negedge clk);
    drv_ready = 1'b0;
    drv_rdata = '0;
    chk($sformatf("v%0d_valid_lat", idx), is_data ? d_valid : i_valid, 1);
    chk($sformatf("v%0d_m_req_drop", idx), m_req, 0);
    if (is_data) chk($sformatf("v%0d_hold_at_valid", idx), hold_o, 0);
    idle_inputs();
    drain();
  endtask

  logic [31:0] cnt;

  initial begin
    //          fetch re  we  addr          wdata         sz     us  mem           lat be     e_wdata       e_rdata
    vecs[0]  = '{1'b1,1'b0,1'b0,32'h0000_0100,32'h0,        2'b10,1'b0,32'h1300_0093,0,4'b1111,32'h0,        32'h1300_0093};
    vecs[1]  = '{1'b0,1'b1,1'b0,32'h0000_0203,32'h0,        2'b00,1'b0,32'h8012_3456,0,4'b1000,32'h0,        32'hFFFF_FF80};
    vecs[2]  = '{1'b0,1'b1,1'b0,32'h0000_0203,32'h0,        2'b00,1'b1,32'h8012_3456,1,4'b1000,32'h0,        32'h0000_0080};
    vecs[3]  = '{1'b0,1'b0,1'b1,32'h0000_0012,32'h1234_BEEF,2'b01,1'b0,32'h0,        2,4'b1100,32'hBEEF_BEEF,32'h0};
    vecs[4]  = '{1'b0,1'b0,1'b1,32'h0000_0201,32'hFFFF_FF5A,2'b00,1'b0,32'h0,        0,4'b0010,32'h5A5A_5A5A,32'h0};
    vecs[5]  = '{1'b0,1'b1,1'b0,32'h0000_0010,32'h0,        2'b01,1'b0,32'h1234_F00D,0,4'b0011,32'h0,        32'hFFFF_F00D};
    vecs[6]  = '{1'b0,1'b1,1'b0,32'h0000_0013,32'h0,        2'b01,1'b1,32'h8001_0000,1,4'b1100,32'h0,        32'h0000_8001};
    vecs[7]  = '{1'b0,1'b1,1'b0,32'h0000_0044,32'h0,        2'b10,1'b0,32'hDEAD_BEEF,3,4'b1111,32'h0,        32'hDEAD_BEEF};
    vecs[8]  = '{1'b0,1'b1,1'b0,32'h0000_0048,32'h0,        2'b11,1'b1,32'hCAFE_F00D,0,4'b1111,32'h0,        32'hCAFE_F00D};
    vecs[9]  = '{1'b0,1'b0,1'b1,32'h0000_0050,32'h1122_3344,2'b10,1'b0,32'h0,        1,4'b1111,32'h1122_3344,32'h0};
    vecs[10] = '{1'b0,1'b1,1'b0,32'h0000_0201,32'h0,        2'b00,1'b0,32'h0000_7F00,0,4'b0010,32'h0,        32'h0000_007F};
    vecs[11] = '{1'b1,1'b0,1'b0,32'h0000_0104,32'h0,        2'b10,1'b0,32'h0000_0013,1,4'b1111,32'h0,        32'h0000_0013};
    vecs[12] = '{1'b0,1'b1,1'b1,32'h0000_0012,32'h0000_00AA,2'b01,1'b0,32'h9ABC_1234,0,4'b1100,32'h0,        32'hFFFF_9ABC};

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_m_req", m_req, 0);
    chk("rst_m_we", m_we, 0);
    chk("rst_m_be", m_be, 0);
    chk("rst_m_addr", m_addr, 0);
    chk("rst_i_valid", i_valid, 0);
    chk("rst_d_valid", d_valid, 0);
    chk("rst_bus_err", bus_err, 0);
    chk("rst_hold_o", hold_o, 0);
    rst = 1'b1;
    mon_en = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 13; i++) run_one(vecs[i], i);

    // Contention: both sides held high, expect D,D,D,D,I repeating
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    auto_ready = 1'b1;
    for (int g = 0; g < 10; g++)
      push_exp((g % 5) != 4, ((g % 5) != 4) ? (32'h0000_0400 ^ K) : (32'h0000_0300 ^ K), 1'b1, 1'b0);
    i_req = 1'b1; i_addr = 32'h300;
    d_re = 1'b1; d_we = 1'b0; d_addr = 32'h400; d_size = 2'b10; d_un_sign = 1'b0;
    repeat (20) @(negedge clk);
    idle_inputs();
    auto_ready = 1'b0;
    drain();
    chk("contention_idle_after", m_req, 0);

    // Timeout on a load with m_ready stuck low
    push_exp(1'b1, 32'h0, 1'b1, 1'b1);
    d_re = 1'b1; d_addr = 32'h80; d_size = 2'b10; drv_ready = 1'b0;
    cnt = '0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (m_req) cnt = cnt + 1;
      else break;
    end
    chk("timeout_req_cycles", cnt, 16);
    chk("timeout_bus_err", bus_err, 1);
    chk("timeout_d_valid", d_valid, 1);
    idle_inputs();
    @(negedge clk);
    chk("timeout_idle_m_req", m_req, 0);
    chk("timeout_err_pulse", bus_err, 0);
    drain();

    // Reset while a data access is waiting on memory
    d_re = 1'b1; d_addr = 32'h90; d_size = 2'b10; drv_ready = 1'b0;
    @(negedge clk);
    chk("rstmid_m_req_up", m_req, 1);
    rst = 1'b0;
    @(negedge clk);
    chk("rstmid_m_req_drop", m_req, 0);
    chk("rstmid_hold_tracks_dre", hold_o, 1);
    chk("rstmid_no_valid", d_valid, 0);
    rst = 1'b1;
    d_re = 1'b0;
    #1 chk("rstmid_hold_released", hold_o, 0);
    repeat (3) @(negedge clk);
    chk("rstmid_still_idle", m_req, 0);
    run_one(vecs[1], 100);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, tests run %0d", n_tests);
    $fatal(1);
  end

endmodule
